// File: rtl/wb_arb.sv
// Register-file write-port arbiter: ex-stage writes pass through combinationally and
// divider results are buffered in a small FIFO that drains whenever ex leaves the port idle.
package tinyriscv_pkg;
  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
endpackage

module wb_arb
  import tinyriscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ex_we_i,
  input  logic [RegAddrBus-1:0] ex_waddr_i,
  input  logic [RegBus-1:0]     ex_wdata_i,
  input  logic                  div_valid_i,
  output logic                  div_ready_o,
  input  logic [RegAddrBus-1:0] div_waddr_i,
  input  logic [RegBus-1:0]     div_wdata_i,
  input  logic [RegAddrBus-1:0] raddr1_i,
  input  logic [RegAddrBus-1:0] raddr2_i,
  output logic                  hazard1_o,
  output logic                  hazard2_o,
  output logic                  we_o,
  output logic [RegAddrBus-1:0] waddr_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic [2:0]            pend_cnt_o
);

  // Storage is sized for the largest legal DEPTH; slots at or above DEPTH are never enqueued.
  localparam int         MAXD    = 4;
  localparam logic [1:0] LAST    = 2'(DEPTH - 1);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [MAXD-1:0]       r_vld;
  logic [RegAddrBus-1:0] r_addr [MAXD];
  logic [RegBus-1:0]     r_data [MAXD];
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [2:0]            r_cnt;

  logic                  w_ex_req;
  logic                  w_xfer;
  logic                  w_enq;
  logic                  w_pop;
  logic                  w_head_vld;
  logic                  w_nonempty;
  logic [MAXD-1:0]       w_squash;
  logic [MAXD-1:0]       w_vld_nxt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_ex_req    = ex_we_i && (ex_waddr_i != '0);
  assign div_ready_o = (r_cnt < DEPTH_C);
  assign w_xfer      = div_valid_i && div_ready_o;
  assign w_enq       = w_xfer && (div_waddr_i != '0);
  assign w_nonempty  = (r_cnt != 3'd0);
  assign w_head_vld  = r_vld[r_head];
  // A squashed head carries no write, so it retires even while ex owns the port.
  assign w_pop       = w_nonempty && (!w_ex_req || !w_head_vld);
  assign pend_cnt_o  = r_cnt;

  always_comb begin
    w_squash  = '0;
    hazard1_o = 1'b0;
    hazard2_o = 1'b0;
    for (int i = 0; i < MAXD; i++) begin
      if (w_ex_req && r_vld[i] && (r_addr[i] == ex_waddr_i)) w_squash[i] = 1'b1;
      if (r_vld[i] && (raddr1_i != '0) && (r_addr[i] == raddr1_i)) hazard1_o = 1'b1;
      if (r_vld[i] && (raddr2_i != '0) && (r_addr[i] == raddr2_i)) hazard2_o = 1'b1;
    end
  end

  always_comb begin
    w_vld_nxt = r_vld & ~w_squash;
    if (w_pop) w_vld_nxt[r_head] = 1'b0;
    if (w_enq) w_vld_nxt[r_tail] = 1'b1;
  end

  always_comb begin
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    if (w_ex_req) begin
      we_o    = 1'b1;
      waddr_o = ex_waddr_i;
      wdata_o = ex_wdata_i;
    end else if (w_nonempty && w_head_vld) begin
      we_o    = 1'b1;
      waddr_o = r_addr[r_head];
      wdata_o = r_data[r_head];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld  <= '0;
      r_head <= 2'd0;
      r_tail <= 2'd0;
      r_cnt  <= 3'd0;
    end else begin
      r_vld <= w_vld_nxt;
      r_cnt <= r_cnt + {2'b00, w_enq} - {2'b00, w_pop};
      if (w_pop) r_head <= ptr_inc(r_head);
      if (w_enq) r_tail <= ptr_inc(r_tail);
    end
  end

  // Payload needs no reset: a slot is only ever read while its valid bit or count covers it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_enq) begin
      r_addr[r_tail] <= div_waddr_i;
      r_data[r_tail] <= div_wdata_i;
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: queue-based reference model predicts each cycle's outputs into a
// scoreboard; an independent monitor compares them against the DUT.
module tb_wb_arb;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        vld;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk_wd;
    logic        rdy;
    logic        h1;
    logic        h2;
    logic [2:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        div_valid;
  logic        div_ready;
  logic [4:0]  div_waddr;
  logic [31:0] div_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hazard1;
  logic        hazard2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  pend_cnt;

  int checks   = 0;
  int failures = 0;

  ent_t        model[$];
  ent_t        div_src[$];
  exp_t        expq[$];
  logic [31:0] rf_model [32];
  logic [31:0] rf_dut   [32];

  wb_arb #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ex_we_i     (ex_we),
    .ex_waddr_i  (ex_waddr),
    .ex_wdata_i  (ex_wdata),
    .div_valid_i (div_valid),
    .div_ready_o (div_ready),
    .div_waddr_i (div_waddr),
    .div_wdata_i (div_wdata),
    .raddr1_i    (raddr1),
    .raddr2_i    (raddr2),
    .hazard1_o   (hazard1),
    .hazard2_o   (hazard2),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .pend_cnt_o  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic hz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (model[i]) if (model[i].vld && (model[i].addr == a)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, predict outputs from the model, then advance the model.
  task automatic step(input logic exwe, input logic [4:0] exa, input logic [31:0] exd,
                      input logic offer, input logic [4:0] r1, input logic [4:0] r2,
                      input logic rstn);
    exp_t e;
    ent_t d;
    logic exreq;
    logic xfer;
    @(negedge clk);
    rst_n     = rstn;
    ex_we     = exwe;
    ex_waddr  = exa;
    ex_wdata  = exd;
    raddr1    = r1;
    raddr2    = r2;
    div_valid = offer && (div_src.size() > 0);
    d = '{addr: 5'd0, data: 32'd0, vld: 1'b1};
    if (div_src.size() > 0) d = div_src[0];
    div_waddr = d.addr;
    div_wdata = d.data;

    exreq    = exwe && (exa != 5'd0);
    e.rdy    = (model.size() < DEPTH);
    e.cnt    = 3'(model.size());
    e.h1     = hz(r1);
    e.h2     = hz(r2);
    e.we     = 1'b0;
    e.wa     = 5'd0;
    e.wd     = 32'd0;
    e.chk_wd = 1'b1;
    if (exreq) begin
      e.we = 1'b1; e.wa = exa; e.wd = exd;
    end else if (model.size() > 0) begin
      if (model[0].vld) begin
        e.we = 1'b1; e.wa = model[0].addr; e.wd = model[0].data;
      end else begin
        e.chk_wd = 1'b0;
      end
    end
    if (e.we) rf_model[e.wa] = e.wd;
    xfer = div_valid && e.rdy;
    #1 expq.push_back(e);

    if (!rstn) begin
      model.delete();
    end else begin
      if ((model.size() > 0) && (!exreq || !model[0].vld)) void'(model.pop_front());
      if (exreq) foreach (model[i]) if (model[i].addr == exa) model[i].vld = 1'b0;
      if (xfer) begin
        void'(div_src.pop_front());
        if (d.addr != 5'd0) model.push_back(d);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
  endtask

  // Monitor: samples away from the clock edge, after the stimulus has posted its prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("we_o", {31'd0, we}, {31'd0, e.we});
        if (e.chk_wd) begin
          chk("waddr_o", {27'd0, waddr}, {27'd0, e.wa});
          chk("wdata_o", wdata, e.wd);
        end
        chk("div_ready_o", {31'd0, div_ready}, {31'd0, e.rdy});
        chk("hazard1_o", {31'd0, hazard1}, {31'd0, e.h1});
        chk("hazard2_o", {31'd0, hazard2}, {31'd0, e.h2});
        chk("pend_cnt_o", {29'd0, pend_cnt}, {29'd0, e.cnt});
        if (we) rf_dut[waddr] = wdata;
      end
    end
  end

  initial begin
    int rf_bad;
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = 32'd0;
      rf_dut[i]   = 32'd0;
    end
    rst_n = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
    div_valid = 1'b0; div_waddr = 5'd0; div_wdata = 32'd0; raddr1 = 5'd0; raddr2 = 5'd0;
    repeat (2) @(posedge clk);

    // Reset state, then ex-only and ex-to-zero.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4, 1'b1);
    step(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd5, 5'd0, 1'b1);
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b1);

    // Single divider result.
    div_src.push_back('{addr: 5'd7, data: 32'h1234_5678, vld: 1'b1});
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b1);

    // Collision with a held ex write fills the buffer, then drains in order.
    div_src.push_back('{addr: 5'd8,  data: 32'h0000_0008, vld: 1'b1});
    div_src.push_back('{addr: 5'd9,  data: 32'h0000_0009, vld: 1'b1});
    div_src.push_back('{addr: 5'd10, data: 32'h0000_000A, vld: 1'b1});
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 32'h3333_0000 + i, 1'b1, 5'd8, 5'd9, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd10, 1'b1);

    // WAW squash: buffered 6 <- 1 overwritten by ex 6 <- 2.
    div_src.push_back('{addr: 5'd6, data: 32'h0000_0001, vld: 1'b1});
    step(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd6, 5'd0, 1'b1);
    step(1'b1, 5'd6, 32'h0000_0002, 1'b0, 5'd6, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd6, 1'b1);
    idle(1);

    // Divider result to register 0 is consumed silently.
    div_src.push_back('{addr: 5'd0, data: 32'hFFFF_FFFF, vld: 1'b1});
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1);
    idle(2);

    // Reset with two entries pending: neither may ever be written.
    div_src.push_back('{addr: 5'd11, data: 32'h0000_0B0B, vld: 1'b1});
    div_src.push_back('{addr: 5'd12, data: 32'h0000_0C0C, vld: 1'b1});
    for (int i = 0; i < 3; i++) step(1'b1, 5'd2, 32'h2222_0000 + i, 1'b1, 5'd11, 5'd12, 1'b1);
    step(1'b1, 5'd2, 32'h2222_00FF, 1'b0, 5'd11, 5'd12, 1'b0);
    idle(3);

    // Randomised traffic over a small address range to provoke collisions.
    for (int n = 0; n < 2000; n++) begin
      logic rst_now;
      if ((div_src.size() < 3) && ($urandom_range(0, 2) == 0))
        div_src.push_back('{addr: 5'($urandom_range(0, 7)), data: $urandom, vld: 1'b1});
      rst_now = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           !rst_now && ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), !rst_now);
    end
    idle(6);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    rf_bad = 0;
    for (int i = 0; i < 32; i++) if (rf_dut[i] !== rf_model[i]) rf_bad++;
    chk("regfile_image", 32'(rf_bad), 32'd0);
    chk("reg6_after_squash_and_random", 32'(rf_dut[6] === rf_model[6]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter: DEPTH, default 2, number of buffered divider results (legal 2..4).
REQ-002 SHALL use RegAddrBus (5) and RegBus (32) from tinyriscv_pkg for all address/data widths.
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 rst_ni  input  1  reset; synchronous, active-low.
REQ-005 ex_we_i  input  1  ex-stage write request; no backpressure.
REQ-006 ex_waddr_i  input  RegAddrBus  ex write address.
REQ-007 ex_wdata_i  input  RegBus  ex write data.
REQ-008 div_valid_i  input  1  divider result valid.
REQ-009 div_ready_o  output  1  arbiter can accept a divider result.
REQ-010 div_waddr_i  input  RegAddrBus  divider destination register.
REQ-011 div_wdata_i  input  RegBus  divider result.
REQ-012 raddr1_i, raddr2_i  input  RegAddrBus each  id-stage read addresses for hazard check.
REQ-013 hazard1_o, hazard2_o  output  1 each  read address has a pending buffered write.
REQ-014 we_o, waddr_o, wdata_o  output  1/RegAddrBus/RegBus  single write port into the register file.
REQ-015 pend_cnt_o  output  3  occupied buffer slots (valid or squashed).

Function
REQ-016 Ex write SHALL pass combinationally to we_o/waddr_o/wdata_o in the same cycle when ex_we_i=1 and ex_waddr_i!=0.
REQ-017 Ex write to address 0 SHALL be treated as no ex request.
REQ-018 Divider handshake: transfer occurs when div_valid_i && div_ready_o at posedge; div_ready_o = (pend_cnt_o < DEPTH), from registered count only.
REQ-019 Transferred divider result with div_waddr_i=0 SHALL be consumed but not enqueued.
REQ-020 Otherwise the result SHALL be written at FIFO tail with valid bit set; minimum latency to we_o is 1 cycle.
REQ-021 Drain: when no ex request and FIFO non-empty, the head SHALL be presented on the write port (we_o = head valid bit) and popped at posedge.
REQ-022 A head with valid bit clear SHALL be popped with we_o=0, even while an ex request owns the port.
REQ-023 WAW squash: each cycle with an ex request, every buffered entry whose address equals ex_waddr_i SHALL have its valid bit cleared at posedge; an entry enqueued that same cycle is not squashed.
REQ-024 Simultaneous enqueue and pop SHALL leave count unchanged; head/tail pointers wrap modulo DEPTH.
REQ-025 hazardN_o SHALL be 1 when raddrN_i!=0 and matches any buffered entry with valid bit set; combinational, excludes the in-flight transfer.
REQ-026 Buffered entries SHALL drain in acceptance order; at most one write per cycle.
REQ-027 When no request and FIFO empty, we_o=0, waddr_o=0, wdata_o=0.

Reset
REQ-028 While rst_ni=0 at posedge: pointers, count, all valid bits cleared; buffered data discarded.
REQ-029 After reset: div_ready_o=1, hazard1_o=hazard2_o=0, pend_cnt_o=0, we_o=0 unless an ex request is present.
REQ-030 Reset asserted mid-drain SHALL drop all pending entries without issuing their writes.

Verification
REQ-031 Ex only: ex_we_i=1, addr 5, data 0xA5A5A5A5 -> same cycle we_o=1, waddr_o=5, wdata_o=0xA5A5A5A5; pend_cnt_o stays 0.
REQ-032 Div only: one transfer addr 7, data 0x12345678 -> next cycle hazard1_o=1 (raddr1_i=7) and we_o=1, waddr_o=7; following cycle pend_cnt_o=0, hazard1_o=0.
REQ-033 Collision/full: DEPTH=2, ex_we_i=1 (addr 3) held 4 cycles, divider offers addr 8, 9, 10 -> div_ready_o=0 after two transfers, pend_cnt_o=2; on ex release writes 8 then 9 issue in order, then 10 accepted.
REQ-034 Squash: buffer holds addr 6 value 0x1; ex writes addr 6 value 0x2 -> hazard on 6 drops next cycle, the buffered entry pops with we_o=0, regfile ends with 0x2.
REQ-035 Zero address: divider transfer to addr 0 -> accepted, pend_cnt_o stays 0, no write issued.
REQ-036 Reset mid-operation: two entries buffered, rst_ni=0 for one posedge -> pend_cnt_o=0, no buffered write ever appears on we_o.
